// File: rtl/dma_layer_sequencer.sv
// Layer-load DMA sequencer: walks DIM -> WGT -> BIAS -> IMG[0..N-1] descriptors,
// one outstanding transfer at a time, with abort and zero-length phase skipping.
module dma_layer_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned IMG_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    cfg_dim_base,
  input  logic [LEN_W-1:0]     cfg_dim_len,
  input  logic [ADDR_W-1:0]    cfg_wgt_base,
  input  logic [LEN_W-1:0]     cfg_wgt_len,
  input  logic [ADDR_W-1:0]    cfg_bias_base,
  input  logic [LEN_W-1:0]     cfg_bias_len,
  input  logic [ADDR_W-1:0]    cfg_img_base,
  input  logic [LEN_W-1:0]     cfg_img_len,
  input  logic [ADDR_W-1:0]    cfg_img_stride,
  input  logic [IMG_CNT_W-1:0] cfg_num_img,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [ADDR_W-1:0]    req_addr,
  output logic [LEN_W-1:0]     req_len,
  output logic [1:0]           req_kind,
  input  logic                 xfer_done,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [IMG_CNT_W-1:0] img_idx
);

  localparam int unsigned CNT_EXT_W = IMG_CNT_W + 1;
  localparam logic [1:0]  KIND_DIM  = 2'd0;
  localparam logic [1:0]  KIND_WGT  = 2'd1;
  localparam logic [1:0]  KIND_BIAS = 2'd2;
  localparam logic [1:0]  KIND_IMG  = 2'd3;

  typedef enum logic [3:0] {
    IDLE, DIM_REQ, DIM_WAIT, WGT_REQ, WGT_WAIT,
    BIAS_REQ, BIAS_WAIT, IMG_REQ, IMG_WAIT, FINISH
  } state_t;

  state_t state, nextState;
  state_t afterWgt, afterBias;

  // Latched configuration; DIM is only ever issued straight out of IDLE so it
  // comes from the cfg inputs directly and needs no copy.
  logic [ADDR_W-1:0]    wgtBase, biasBase, imgStride;
  logic [LEN_W-1:0]     wgtLen, biasLen, imgLen;
  logic [IMG_CNT_W-1:0] numImg;

  // Running image address (accumulator instead of base + k*stride).
  logic [ADDR_W-1:0]    imgAddr, imgAddrInc;
  logic                 abortPend;

  logic                 handshake, inReq, moreImg, imgAdvance, abortReq;

  logic                 reqValidNxt, busyNxt, doneNxt, abortedNxt;
  logic [ADDR_W-1:0]    reqAddrNxt;
  logic [LEN_W-1:0]     reqLenNxt;
  logic [1:0]           reqKindNxt;

  assign handshake  = req_valid && req_ready;
  assign inReq      = state inside {DIM_REQ, WGT_REQ, BIAS_REQ, IMG_REQ};
  assign abortReq   = abort || abortPend;
  assign imgAddrInc = imgAddr + imgStride;
  assign moreImg    = ({1'b0, img_idx} + CNT_EXT_W'(1)) < {1'b0, numImg};
  assign imgAdvance = (state == IMG_WAIT) && xfer_done && !abort && moreImg;
  assign afterBias  = ((numImg != '0) && (imgLen != '0)) ? IMG_REQ : FINISH;
  assign afterWgt   = (biasLen != '0) ? BIAS_REQ : afterBias;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; abort in a WAIT state beats a simultaneous xfer_done
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (start) nextState = (cfg_dim_len != '0) ? DIM_REQ : WGT_REQ;
      DIM_REQ:   if (handshake) nextState = abortReq ? IDLE : DIM_WAIT;
      WGT_REQ:   if (handshake) nextState = abortReq ? IDLE : WGT_WAIT;
      BIAS_REQ:  if (handshake) nextState = abortReq ? IDLE : BIAS_WAIT;
      IMG_REQ:   if (handshake) nextState = abortReq ? IDLE : IMG_WAIT;
      DIM_WAIT:  if (abort) nextState = IDLE; else if (xfer_done) nextState = WGT_REQ;
      WGT_WAIT:  if (abort) nextState = IDLE; else if (xfer_done) nextState = afterWgt;
      BIAS_WAIT: if (abort) nextState = IDLE; else if (xfer_done) nextState = afterBias;
      IMG_WAIT:  if (abort) nextState = IDLE;
                 else if (xfer_done) nextState = moreImg ? IMG_REQ : FINISH;
      FINISH:    nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs, keyed on nextState
  always_comb begin
    reqValidNxt = nextState inside {DIM_REQ, WGT_REQ, BIAS_REQ, IMG_REQ};
    busyNxt     = (nextState != IDLE);
    doneNxt     = (nextState == FINISH);
    abortedNxt  = (state != IDLE) && (state != FINISH) && (nextState == IDLE);
    reqAddrNxt  = req_addr;
    reqLenNxt   = req_len;
    reqKindNxt  = req_kind;
    if (nextState != state) begin
      case (nextState)
        DIM_REQ: begin
          reqAddrNxt = cfg_dim_base;
          reqLenNxt  = cfg_dim_len;
          reqKindNxt = KIND_DIM;
        end
        WGT_REQ: begin
          reqAddrNxt = (state == IDLE) ? cfg_wgt_base : wgtBase;
          reqLenNxt  = (state == IDLE) ? cfg_wgt_len  : wgtLen;
          reqKindNxt = KIND_WGT;
        end
        BIAS_REQ: begin
          reqAddrNxt = biasBase;
          reqLenNxt  = biasLen;
          reqKindNxt = KIND_BIAS;
        end
        IMG_REQ: begin
          reqAddrNxt = (state == IMG_WAIT) ? imgAddrInc : imgAddr;
          reqLenNxt  = imgLen;
          reqKindNxt = KIND_IMG;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_len   <= '0;
      req_kind  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      req_valid <= reqValidNxt;
      req_addr  <= reqAddrNxt;
      req_len   <= reqLenNxt;
      req_kind  <= reqKindNxt;
      busy      <= busyNxt;
      done      <= doneNxt;
      aborted   <= abortedNxt;
    end
  end

  // Config latch, image counter/accumulator and pending-abort flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wgtBase   <= '0;
      wgtLen    <= '0;
      biasBase  <= '0;
      biasLen   <= '0;
      imgLen    <= '0;
      imgStride <= '0;
      numImg    <= '0;
      imgAddr   <= '0;
      img_idx   <= '0;
      abortPend <= 1'b0;
    end else if ((state == IDLE) && start) begin
      wgtBase   <= cfg_wgt_base;
      wgtLen    <= cfg_wgt_len;
      biasBase  <= cfg_bias_base;
      biasLen   <= cfg_bias_len;
      imgLen    <= cfg_img_len;
      imgStride <= cfg_img_stride;
      numImg    <= cfg_num_img;
      imgAddr   <= cfg_img_base;
      img_idx   <= '0;
      abortPend <= 1'b0;
    end else begin
      if (imgAdvance) begin
        img_idx <= img_idx + IMG_CNT_W'(1);
        imgAddr <= imgAddrInc;
      end
      if (nextState == IDLE)                abortPend <= 1'b0;
      else if (inReq && abort && !req_ready) abortPend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_layer_sequencer.sv
// Directed bench for dma_layer_sequencer: full load, skips, backpressure,
// abort, address wrap with noise, and mid-load reset.
module tb_dma_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] cfg_dim_base, cfg_wgt_base, cfg_bias_base, cfg_img_base, cfg_img_stride;
  logic [15:0] cfg_dim_len, cfg_wgt_len, cfg_bias_len, cfg_img_len;
  logic [7:0]  cfg_num_img;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  req_kind;
  logic        xfer_done, busy, done, aborted;
  logic [7:0]  img_idx;

  int passCnt  = 0;
  int checkCnt = 0;
  int failCnt  = 0;
  int hsCnt    = 0;
  int doneCnt  = 0;
  int abortCnt = 0;
  int h0, d0, a0;

  dma_layer_sequencer #(.ADDR_W(32), .LEN_W(16), .IMG_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_dim_base(cfg_dim_base), .cfg_dim_len(cfg_dim_len),
    .cfg_wgt_base(cfg_wgt_base), .cfg_wgt_len(cfg_wgt_len),
    .cfg_bias_base(cfg_bias_base), .cfg_bias_len(cfg_bias_len),
    .cfg_img_base(cfg_img_base), .cfg_img_len(cfg_img_len),
    .cfg_img_stride(cfg_img_stride), .cfg_num_img(cfg_num_img),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_kind(req_kind), .xfer_done(xfer_done),
    .busy(busy), .done(done), .aborted(aborted), .img_idx(img_idx)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (req_valid && req_ready) hsCnt++;
    if (done) doneCnt++;
    if (aborted) abortCnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setCfg(input logic [31:0] db, input logic [15:0] dl,
                        input logic [31:0] wb, input logic [15:0] wl,
                        input logic [31:0] bb, input logic [15:0] bl,
                        input logic [31:0] ib, input logic [15:0] il,
                        input logic [31:0] is, input logic [7:0] n);
    cfg_dim_base = db;  cfg_dim_len = dl;
    cfg_wgt_base = wb;  cfg_wgt_len = wl;
    cfg_bias_base = bb; cfg_bias_len = bl;
    cfg_img_base = ib;  cfg_img_len = il;
    cfg_img_stride = is; cfg_num_img = n;
  endtask

  task automatic doStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Accept one descriptor (optionally stalling), then complete it after lat cycles (lat=0: no completion)
  task automatic serve(input string tag, input logic [31:0] eAddr, input logic [15:0] eLen,
                       input logic [1:0] eKind, input logic [7:0] eIdx, input int stall, input int lat);
    int n;
    n = 0;
    while (!req_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 64'(req_valid), 64'd1);
    chk({tag, "_addr"},  64'(req_addr),  64'(eAddr));
    chk({tag, "_len"},   64'(req_len),   64'(eLen));
    chk({tag, "_kind"},  64'(req_kind),  64'(eKind));
    if (eKind == 2'd3) chk({tag, "_idx"}, 64'(img_idx), 64'(eIdx));
    for (int i = 1; i < stall; i++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(req_valid), 64'd1);
      chk({tag, "_hold_addr"},  64'(req_addr),  64'(eAddr));
      chk({tag, "_hold_len"},   64'(req_len),   64'(eLen));
      chk({tag, "_hold_kind"},  64'(req_kind),  64'(eKind));
    end
    req_ready = 1'b1;
    step();
    chk({tag, "_valid_drop"}, 64'(req_valid), 64'd0);
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) step();
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; req_ready = 1'b1; xfer_done = 1'b0;
    setCfg(32'h0, 16'h0, 32'h0, 16'h0, 32'h0, 16'h0, 32'h0, 16'h0, 32'h0, 8'h0);
    step(); step();
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_addr",  64'(req_addr),  64'd0);
    chk("rst_idx",   64'(img_idx),   64'd0);
    rst_n = 1'b1;
    step();

    // 1: full load with three images
    setCfg(32'h1000, 16'd16, 32'h2000, 16'd4096, 32'h3000, 16'd64,
           32'h8000, 16'd784, 32'h400, 8'd3);
    h0 = hsCnt; d0 = doneCnt;
    doStart();
    chk("t1_busy", 64'(busy), 64'd1);
    serve("t1_dim",  32'h1000, 16'd16,   2'd0, 8'd0, 0, 5);
    serve("t1_wgt",  32'h2000, 16'd4096, 2'd1, 8'd0, 0, 5);
    serve("t1_bias", 32'h3000, 16'd64,   2'd2, 8'd0, 0, 5);
    serve("t1_img0", 32'h8000, 16'd784,  2'd3, 8'd0, 0, 5);
    serve("t1_img1", 32'h8400, 16'd784,  2'd3, 8'd1, 0, 5);
    serve("t1_img2", 32'h8800, 16'd784,  2'd3, 8'd2, 0, 5);
    chk("t1_done",      64'(done), 64'd1);
    chk("t1_busy_fin",  64'(busy), 64'd1);
    step();
    chk("t1_done_drop", 64'(done), 64'd0);
    chk("t1_busy_drop", 64'(busy), 64'd0);
    chk("t1_hs_count",  64'(hsCnt - h0),   64'd6);
    chk("t1_done_count", 64'(doneCnt - d0), 64'd1);

    // 2: dims, bias and images skipped; zero-length weights still issued
    setCfg(32'h1000, 16'd0, 32'h2000, 16'd0, 32'h3000, 16'd0,
           32'h8000, 16'd784, 32'h400, 8'd0);
    h0 = hsCnt;
    doStart();
    serve("t2_wgt", 32'h2000, 16'd0, 2'd1, 8'd0, 0, 5);
    chk("t2_done", 64'(done), 64'd1);
    step();
    chk("t2_busy_drop", 64'(busy), 64'd0);
    chk("t2_hs_count", 64'(hsCnt - h0), 64'd1);

    // 3: weights request held off for 7 cycles
    setCfg(32'h1000, 16'd0, 32'h2400, 16'd512, 32'h3000, 16'd0,
           32'h8000, 16'd784, 32'h400, 8'd0);
    h0 = hsCnt;
    req_ready = 1'b0;
    doStart();
    serve("t3_wgt", 32'h2400, 16'd512, 2'd1, 8'd0, 7, 5);
    chk("t3_done", 64'(done), 64'd1);
    step();
    chk("t3_hs_count", 64'(hsCnt - h0), 64'd1);

    // 4a: abort while waiting on image 1 of 4, then a stray completion
    setCfg(32'h1000, 16'd16, 32'h2000, 16'd32, 32'h3000, 16'd64,
           32'h8000, 16'd100, 32'h400, 8'd4);
    d0 = doneCnt; a0 = abortCnt;
    doStart();
    serve("t4_dim",  32'h1000, 16'd16,  2'd0, 8'd0, 0, 5);
    serve("t4_wgt",  32'h2000, 16'd32,  2'd1, 8'd0, 0, 5);
    serve("t4_bias", 32'h3000, 16'd64,  2'd2, 8'd0, 0, 5);
    serve("t4_img0", 32'h8000, 16'd100, 2'd3, 8'd0, 0, 5);
    serve("t4_img1", 32'h8400, 16'd100, 2'd3, 8'd1, 0, 0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_aborted", 64'(aborted), 64'd1);
    chk("t4_busy",    64'(busy),    64'd0);
    step();
    chk("t4_aborted_drop", 64'(aborted), 64'd0);
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    step();
    chk("t4_stray_busy",  64'(busy),      64'd0);
    chk("t4_stray_valid", 64'(req_valid), 64'd0);
    chk("t4_stray_idx",   64'(img_idx),   64'd1);
    chk("t4_no_done",     64'(doneCnt - d0),  64'd0);
    chk("t4_abort_count", 64'(abortCnt - a0), 64'd1);

    // 4b: abort during a stalled image request stays pending until accepted
    setCfg(32'h1000, 16'd0, 32'h2000, 16'd32, 32'h3000, 16'd0,
           32'h9000, 16'd100, 32'h10, 8'd2);
    a0 = abortCnt; h0 = hsCnt;
    doStart();
    serve("t4b_wgt", 32'h2000, 16'd32, 2'd1, 8'd0, 0, 0);
    req_ready = 1'b0;
    repeat (4) step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("t4b_img_valid", 64'(req_valid), 64'd1);
    chk("t4b_img_addr",  64'(req_addr),  64'h9000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step(); step();
    chk("t4b_pend_valid",   64'(req_valid), 64'd1);
    chk("t4b_pend_addr",    64'(req_addr),  64'h9000);
    chk("t4b_pend_busy",    64'(busy),      64'd1);
    chk("t4b_pend_aborted", 64'(aborted),   64'd0);
    req_ready = 1'b1;
    step();
    chk("t4b_aborted", 64'(aborted),   64'd1);
    chk("t4b_busy",    64'(busy),      64'd0);
    chk("t4b_valid",   64'(req_valid), 64'd0);
    chk("t4b_hs_count", 64'(hsCnt - h0), 64'd2);
    step();
    chk("t4b_abort_count", 64'(abortCnt - a0), 64'd1);

    // 5: image address wrap, with start/xfer_done noise during a request
    setCfg(32'h1000, 16'd16, 32'h2000, 16'd32, 32'h3000, 16'd0,
           32'hFFFF_FC00, 16'd32, 32'h400, 8'd2);
    req_ready = 1'b0;
    doStart();
    xfer_done = 1'b1;
    start = 1'b1;
    cfg_wgt_base = 32'hDEAD_0000;
    step();
    xfer_done = 1'b0;
    start = 1'b0;
    chk("t5_noise_valid", 64'(req_valid), 64'd1);
    chk("t5_noise_addr",  64'(req_addr),  64'h1000);
    chk("t5_noise_kind",  64'(req_kind),  64'd0);
    req_ready = 1'b1;
    serve("t5_dim",  32'h1000,      16'd16, 2'd0, 8'd0, 0, 5);
    serve("t5_wgt",  32'h2000,      16'd32, 2'd1, 8'd0, 0, 5);
    serve("t5_img0", 32'hFFFF_FC00, 16'd32, 2'd3, 8'd0, 0, 5);
    serve("t5_img1", 32'h0000_0000, 16'd32, 2'd3, 8'd1, 0, 5);
    chk("t5_done", 64'(done), 64'd1);
    step();

    // 6: reset during bias wait, then a clean restart
    setCfg(32'h1000, 16'd16, 32'h2000, 16'd32, 32'h3000, 16'd64,
           32'h8000, 16'd100, 32'h400, 8'd1);
    d0 = doneCnt; a0 = abortCnt;
    doStart();
    serve("t6_dim",  32'h1000, 16'd16, 2'd0, 8'd0, 0, 5);
    serve("t6_wgt",  32'h2000, 16'd32, 2'd1, 8'd0, 0, 5);
    serve("t6_bias", 32'h3000, 16'd64, 2'd2, 8'd0, 0, 0);
    rst_n = 1'b0;
    step();
    chk("t6_rst_valid",   64'(req_valid), 64'd0);
    chk("t6_rst_addr",    64'(req_addr),  64'd0);
    chk("t6_rst_len",     64'(req_len),   64'd0);
    chk("t6_rst_kind",    64'(req_kind),  64'd0);
    chk("t6_rst_busy",    64'(busy),      64'd0);
    chk("t6_rst_done",    64'(done),      64'd0);
    chk("t6_rst_aborted", 64'(aborted),   64'd0);
    rst_n = 1'b1;
    step();
    chk("t6_no_pulses", 64'((doneCnt - d0) + (abortCnt - a0)), 64'd0);
    doStart();
    serve("t6r_dim",  32'h1000, 16'd16,  2'd0, 8'd0, 0, 5);
    serve("t6r_wgt",  32'h2000, 16'd32,  2'd1, 8'd0, 0, 5);
    serve("t6r_bias", 32'h3000, 16'd64,  2'd2, 8'd0, 0, 5);
    serve("t6r_img0", 32'h8000, 16'd100, 2'd3, 8'd0, 0, 5);
    chk("t6r_done", 64'(done), 64'd1);
    step();
    chk("t6r_busy_drop", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
